fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the write port of one sync_fifo among NREQ producers. Round-robin arbitration
//  between requesters, with packet lock: the owner keeps the port until its last beat.
//  Sits in front of the FIFO. Drives its wr_en/din and back-pressures on full.
//  Zero-latency, single-cycle grant: a beat is written on the same edge it is granted.
// PARAMETERS
//  NREQ    4   number of requesters, >=2
//  DWIDTH  16  data width; matches the FIFO DWIDTH
//  CNTW    16  width of each per-requester beat counter (FIFO_ARB_STATS_EN only)
// PORTS
//  clk          in   1            clock; all state updates on the rising edge
//  rstn         in   1            reset, synchronous, active-low
//  req          in   NREQ         req[i]=1: requester i presents a beat
//  req_last     in   NREQ         req_last[i]=1: this beat ends requester i's packet
//  req_data     in   NREQ*DWIDTH  beat data for requester i, at [i*DWIDTH +: DWIDTH]
//  gnt          out  NREQ         one-hot, combinational; beat accepted this cycle
//  fifo_full    in   1            FIFO full flag
//  fifo_wr_en   out  1            FIFO write enable = |gnt
//  fifo_din     out  DWIDTH       data of the granted requester; 0 when no grant
//  busy         out  1            registered; 1 while a packet lock is held
//  owner        out  $clog2(NREQ) registered; current lock owner, else last granted index
// BEHAVIOUR
//  - Reset (rstn=0 at an edge): state=IDLE, rr_ptr=0, owner=0, busy=0, counters=0.
//    While rstn=0: gnt=0, fifo_wr_en=0, fifo_din=0.
//  - Grant is never issued while fifo_full=1. State, rr_ptr and owner are held during full.
//  - FSM IDLE: winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... (mod NREQ).
//    No req -> no grant, no change.
//    Winner with req_last=1 -> single beat; stay IDLE; rr_ptr<=winner+1 (NREQ-1 wraps to 0).
//    Winner with req_last=0 -> LOCK; owner<=winner; busy<=1.
//  - FSM LOCK: only the owner is eligible. gnt[owner]=req[owner]&!fifo_full.
//    Other requests are ignored.
//    Owner beat with req_last=1 -> IDLE; busy<=0; rr_ptr<=owner+1.
//    Owner deasserting req stalls the lock indefinitely. There is no timeout.
//  - owner updates to the winner on every IDLE grant.
//  - Requesters hold req/req_last/req_data stable until gnt[i]=1.
//  - Reset mid-packet drops the lock immediately. Beats already written stay in the FIFO.
//    No recovery or retraction is performed here.
//  - fifo_din mux is combinational from req_data, selected by the grant vector.
// CONFIGURATION
//  FIFO_ARB_STATS_EN defined: adds two ports.
//    stat_clr  in   1          synchronous clear of all counters
//    stat_cnt  out  NREQ*CNTW  counter i at [i*CNTW +: CNTW]
//    Counter i increments once per granted beat of requester i.
//    Saturates at 2**CNTW-1. stat_clr wins over a same-cycle increment.
//  FIFO_ARB_STATS_EN undefined: ports and counters are absent; arbitration is identical.
// TESTING
//  1 reset, req=0000 -> gnt=0000, fifo_wr_en=0, fifo_din=0, busy=0, owner=0
//  2 req=1111, req_last=1111, full=0, data_i=16'hA0+i, 8 cycles
//    -> gnt 0001,0010,0100,1000,0001,...; FIFO receives A0,A1,A2,A3,A0,...
//  3 req0 sends a 3-beat packet (last on beat 3) while req1 holds single beats
//    -> gnt=0001 x3 back-to-back; busy=1 from after beat1 to after beat3; then gnt=0010
//  4 rr_ptr=1, req=0110, full=1 for 3 cycles
//    -> gnt=0000, wr_en=0, state held; cycle after full=0 -> gnt=0010
//  5 rstn=0 for 1 cycle while locked on owner 2, then req=1111
//    -> busy=0, owner=0, first grant gnt=0001
//  6 [STATS_EN] 5 single beats from req2 -> stat_cnt[2]=5
//    stat_clr with a same-cycle grant -> 0
//    CNTW=2: 6 beats -> 3 (saturated)

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for one sync_fifo, with packet lock held until the owner's last beat.
// Optional per-requester beat counters when FIFO_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 16,
    parameter int CNTW   = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_last,
    input  logic [NREQ*DWIDTH-1:0]     req_data,
    output logic [NREQ-1:0]            gnt,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [DWIDTH-1:0]          fifo_din,
    output logic                       busy,
    output logic [$clog2(NREQ)-1:0]    owner
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [NREQ*CNTW-1:0]       stat_cnt
`endif
);

    localparam int IW = $clog2(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [IW:0]   NREQ_W   = (IW + 1)'(NREQ);

    if (NREQ < 2 || CNTW < 1) begin : g_bad_params
        $error("fifo_wr_arbiter: NREQ must be >= 2 and CNTW >= 1");
    end

    // Handshake: gnt[i] is combinational and means the beat on req_data[i] is written to
    // the FIFO at this rising edge; requesters hold req/req_last/req_data until gnt[i]=1.
    typedef enum logic {ST_IDLE, ST_LOCK} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_owner;
    logic            r_busy;

    logic [IW:0]     w_cand;
    logic [IW-1:0]   w_winner;
    logic            w_found;
    logic [IW-1:0]   w_sel;
    logic            w_sel_valid;
    logic            w_accept;
    logic [NREQ-1:0] w_gnt;
    logic [DWIDTH-1:0] w_din;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // Scan starts at the round-robin pointer and wraps modulo NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (IW + 1)'(k);
            if (w_cand >= NREQ_W) w_cand = w_cand - NREQ_W;
            if (!w_found && req[w_cand[IW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IW-1:0];
            end
        end
    end

    always_comb begin
        w_sel       = (r_state == ST_LOCK) ? r_owner : w_winner;
        w_sel_valid = (r_state == ST_LOCK) ? req[r_owner] : w_found;
        w_accept    = rstn && !fifo_full && w_sel_valid;
        w_gnt       = '0;
        if (w_accept) w_gnt[w_sel] = 1'b1;
    end

    always_comb begin
        w_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) w_din = w_din | req_data[i*DWIDTH +: DWIDTH];
        end
    end

    // The granted beat decides the next state: a last beat frees the port and advances
    // the pointer past the grantee, any other beat (re)asserts the lock on it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_busy   <= 1'b0;
        end else if (w_accept) begin
            r_owner <= w_sel;
            if (req_last[w_sel]) begin
                r_state  <= ST_IDLE;
                r_busy   <= 1'b0;
                r_rr_ptr <= next_idx(w_sel);
            end else begin
                r_state <= ST_LOCK;
                r_busy  <= 1'b1;
            end
        end
    end

    assign gnt        = w_gnt;
    assign fifo_wr_en = |w_gnt;
    assign fifo_din   = w_din;
    assign busy       = r_busy;
    assign owner      = r_owner;

`ifdef FIFO_ARB_STATS_EN
    logic [CNTW-1:0] r_cnt [NREQ];

    // Clear has priority over a same-cycle increment; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rstn || stat_clr) begin
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_gnt[i] && (r_cnt[i] != {CNTW{1'b1}})) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < NREQ; i++) stat_cnt[i*CNTW +: CNTW] = r_cnt[i];
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (NREQ=4, DWIDTH=16).
module tb_fifo_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DWIDTH = 16;
    localparam int CNTW   = 16;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        req_last = '0;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        gnt;
    logic                   fifo_full = 1'b0;
    logic                   fifo_wr_en;
    logic [DWIDTH-1:0]      fifo_din;
    logic                   busy;
    logic [1:0]             owner;
`ifdef FIFO_ARB_STATS_EN
    logic                   stat_clr = 1'b0;
    logic [NREQ*CNTW-1:0]   stat_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        rstn;
        logic [3:0]  req;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  gnt;
        logic [15:0] din;
        logic        busy;
        logic [1:0]  owner;
    } vec_t;

    vec_t vecs[$];

    fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .CNTW(CNTW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .req_last   (req_last),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy),
        .owner      (owner)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_cnt   (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic r, logic [3:0] rq, logic [3:0] ls, logic f,
                                logic [3:0] g, logic [15:0] d, logic b, logic [1:0] o);
        vec_t v;
        v.name = name; v.rstn = r; v.req = rq; v.last = ls; v.full = f;
        v.gnt = g; v.din = d; v.busy = b; v.owner = o;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, compare 1ns later; busy/owner reflect the previous edge.
    task automatic apply(vec_t v);
        @(negedge clk);
        rstn      = v.rstn;
        req       = v.req;
        req_last  = v.last;
        fifo_full = v.full;
        #1;
        check({v.name, ".gnt"},   32'(gnt),        32'(v.gnt));
        check({v.name, ".wr_en"}, 32'(fifo_wr_en), 32'(|v.gnt));
        check({v.name, ".din"},   32'(fifo_din),   32'(v.din));
        check({v.name, ".busy"},  32'(busy),       32'(v.busy));
        check({v.name, ".owner"}, 32'(owner),      32'(v.owner));
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) req_data[i*DWIDTH +: DWIDTH] = 16'(16'hA0 + i);

        // name rstn req last full | gnt din busy owner
        vecs.push_back(mk("reset_idle",   1, 4'b0000, 4'b0000, 0, 4'b0000, 16'h00, 0, 0));
        vecs.push_back(mk("in_reset",     0, 4'b1111, 4'b1111, 0, 4'b0000, 16'h00, 0, 0));
        vecs.push_back(mk("rr0",          1, 4'b1111, 4'b1111, 0, 4'b0001, 16'hA0, 0, 0));
        vecs.push_back(mk("rr1",          1, 4'b1111, 4'b1111, 0, 4'b0010, 16'hA1, 0, 0));
        vecs.push_back(mk("rr2",          1, 4'b1111, 4'b1111, 0, 4'b0100, 16'hA2, 0, 1));
        vecs.push_back(mk("rr3",          1, 4'b1111, 4'b1111, 0, 4'b1000, 16'hA3, 0, 2));
        vecs.push_back(mk("rr4_wrap",     1, 4'b1111, 4'b1111, 0, 4'b0001, 16'hA0, 0, 3));
        vecs.push_back(mk("rr5",          1, 4'b1111, 4'b1111, 0, 4'b0010, 16'hA1, 0, 0));
        vecs.push_back(mk("rr6",          1, 4'b1111, 4'b1111, 0, 4'b0100, 16'hA2, 0, 1));
        vecs.push_back(mk("rr7",          1, 4'b1111, 4'b1111, 0, 4'b1000, 16'hA3, 0, 2));
        vecs.push_back(mk("pkt_beat1",    1, 4'b0011, 4'b0010, 0, 4'b0001, 16'hA0, 0, 3));
        vecs.push_back(mk("pkt_beat2",    1, 4'b0011, 4'b0010, 0, 4'b0001, 16'hA0, 1, 0));
        vecs.push_back(mk("pkt_stall",    1, 4'b0010, 4'b0010, 0, 4'b0000, 16'h00, 1, 0));
        vecs.push_back(mk("pkt_beat3",    1, 4'b0011, 4'b0011, 0, 4'b0001, 16'hA0, 1, 0));
        vecs.push_back(mk("pkt_after",    1, 4'b0010, 4'b0010, 0, 4'b0010, 16'hA1, 0, 0));
        vecs.push_back(mk("ptr_to1",      1, 4'b0001, 4'b0001, 0, 4'b0001, 16'hA0, 0, 1));
        vecs.push_back(mk("full_c1",      1, 4'b0110, 4'b0110, 1, 4'b0000, 16'h00, 0, 0));
        vecs.push_back(mk("full_c2",      1, 4'b0110, 4'b0110, 1, 4'b0000, 16'h00, 0, 0));
        vecs.push_back(mk("full_c3",      1, 4'b0110, 4'b0110, 1, 4'b0000, 16'h00, 0, 0));
        vecs.push_back(mk("full_release", 1, 4'b0110, 4'b0110, 0, 4'b0010, 16'hA1, 0, 0));
        vecs.push_back(mk("lock_own2",    1, 4'b0100, 4'b0000, 0, 4'b0100, 16'hA2, 0, 1));
        vecs.push_back(mk("rst_in_lock",  0, 4'b1111, 4'b1111, 0, 4'b0000, 16'h00, 1, 2));
        vecs.push_back(mk("post_rst",     1, 4'b1111, 4'b1111, 0, 4'b0001, 16'hA0, 0, 0));

        rstn = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Lock on the highest index survives a full FIFO, then its release wraps the pointer to 0.
        apply(mk("lk3_start",   1, 4'b1000, 4'b0000, 0, 4'b1000, 16'hA3, 0, 0));
        apply(mk("lk3_full1",   1, 4'b1001, 4'b1001, 1, 4'b0000, 16'h00, 1, 3));
        apply(mk("lk3_full2",   1, 4'b1001, 4'b1001, 1, 4'b0000, 16'h00, 1, 3));
        apply(mk("lk3_last",    1, 4'b1001, 4'b1001, 0, 4'b1000, 16'hA3, 1, 3));
        apply(mk("lk3_wrap",    1, 4'b1001, 4'b1001, 0, 4'b0001, 16'hA0, 0, 3));
        apply(mk("lk3_next",    1, 4'b1001, 4'b1001, 0, 4'b1000, 16'hA3, 0, 0));

`ifdef FIFO_ARB_STATS_EN
        // Clear while requester 2 is granted: clear wins, then five more beats count up.
        @(negedge clk);
        stat_clr = 1'b1; req = 4'b0100; req_last = 4'b0100; fifo_full = 1'b0;
        #1 check("stat_clr_gnt", 32'(gnt), 32'(4'b0100));
        @(negedge clk);
        stat_clr = 1'b0; req = 4'b0000;
        #1 check("stat_clr_wins", 32'(stat_cnt[2*CNTW +: CNTW]), 32'd0);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            req = 4'b0100; req_last = 4'b0100;
        end
        @(negedge clk);
        req = 4'b0000;
        #1;
        check("stat_cnt2_5", 32'(stat_cnt[2*CNTW +: CNTW]), 32'd5);
        check("stat_cnt0_0", 32'(stat_cnt[0*CNTW +: CNTW]), 32'd0);
`endif

        @(negedge clk);
        req = '0; req_last = '0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
